// File: rtl/pulse_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | pulse_pkg : shared types and defaults for the pulse_train_ctrl slice        |
// | Revision  : 1.0                                                            |
// +----------------------------------------------------------------------------+
package pulse_pkg;

    localparam int C_CNT_W = 32;
    localparam int C_IDX_W = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } pt_state_e;

    // Shadow fields are held at the default (maximum) widths; modules narrow on read.
    typedef struct packed {
        logic [C_CNT_W-1:0] width;
        logic [C_CNT_W-1:0] period;
        logic [C_IDX_W-1:0] count;
    } pt_cfg_t;

    // Pure magnitude compare, so a period shorter than the width cannot wrap.
    function automatic logic cfg_geometry_ok(input logic [C_CNT_W-1:0] width,
                                             input logic [C_CNT_W-1:0] period);
        return (width != '0) && (period > width);
    endfunction

endpackage
`default_nettype wire

// File: rtl/pulse_generate.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | pulse_generate : single-shot pulse of pulse_width cycles per start_evt      |
// | Revision       : 1.0                                                       |
// +----------------------------------------------------------------------------+
module pulse_generate #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_evt,
    input  logic [CNT_W-1:0] pulse_width,
    output logic             pulse_out
);

    logic             r_pulse;
    logic [CNT_W-1:0] r_remain;

    // Pulse rises the cycle after start_evt and stays high for pulse_width cycles.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pulse  <= 1'b0;
            r_remain <= '0;
        end else if (start_evt && (pulse_width != '0)) begin
            r_pulse  <= 1'b1;
            r_remain <= pulse_width - CNT_W'(1);
        end else if (r_pulse) begin
            if (r_remain == '0) begin
                r_pulse <= 1'b0;
            end else begin
                r_remain <= r_remain - CNT_W'(1);
            end
        end
    end

    assign pulse_out = r_pulse;

endmodule
`default_nettype wire

// File: rtl/pulse_train_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | pulse_train_ctrl : start/stop sequencer for a train of equal-width pulses   |
// | Option   : PULSE_TRAIN_INFINITE_EN (cfg_count == 0 -> endless train)        |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module pulse_train_ctrl
    import pulse_pkg::*;
#(
    parameter int CNT_W = C_CNT_W,
    parameter int IDX_W = C_IDX_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             stop,
    input  logic [CNT_W-1:0] cfg_width,
    input  logic [CNT_W-1:0] cfg_period,
    input  logic [IDX_W-1:0] cfg_count,
    output logic             pulse_out,
    output logic             busy,
    output logic             done,
    output logic             cfg_err,
    output logic [IDX_W-1:0] pulse_idx
);

    pt_state_e        r_state;
    pt_state_e        w_state_nxt;
    pt_cfg_t          r_cfg;
    logic [CNT_W-1:0] r_per_cnt;
    logic [IDX_W-1:0] r_pulse_idx;
    logic             r_done;
    logic             r_cfg_err;

    logic [CNT_W-1:0] w_width;
    logic [CNT_W-1:0] w_period;
    logic [IDX_W-1:0] w_count;
    logic [CNT_W-1:0] w_per_cnt_inc;
    logic             w_count_ok;
    logic             w_infinite;
    logic             w_cfg_ok;
    logic             w_accept;
    logic             w_reject;
    logic             w_fire;
    logic             w_last_fire;
    logic             w_pulse_ending;
    logic             w_done_nxt;
    logic             w_gen_rst;

    assign w_width  = CNT_W'(r_cfg.width);
    assign w_period = CNT_W'(r_cfg.period);
    assign w_count  = IDX_W'(r_cfg.count);

`ifdef PULSE_TRAIN_INFINITE_EN
    assign w_count_ok = 1'b1;
    assign w_infinite = (w_count == '0);
`else
    assign w_count_ok = (cfg_count != '0);
    assign w_infinite = 1'b0;
`endif

    assign w_cfg_ok = cfg_geometry_ok(C_CNT_W'(cfg_width), C_CNT_W'(cfg_period)) && w_count_ok;
    assign w_accept = (r_state == IDLE) && start && w_cfg_ok;
    assign w_reject = (r_state == IDLE) && start && !w_cfg_ok;

    assign w_fire      = (r_state == RUN) && (r_per_cnt == '0) && !stop;
    assign w_last_fire = w_fire && !w_infinite && ((r_pulse_idx + IDX_W'(1)) == w_count);

    // A pulse fired at per_cnt == 0 is high for per_cnt 1..width, so its last
    // high cycle is per_cnt == width; this lets done land on the first low cycle.
    assign w_pulse_ending = pulse_out && (r_per_cnt == w_width);
    assign w_per_cnt_inc  = r_per_cnt + CNT_W'(1);

    always_comb begin
        w_state_nxt = r_state;
        w_done_nxt  = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_state_nxt = RUN;
                end
            end
            RUN: begin
                if (stop) begin
                    if (!pulse_out || w_pulse_ending) begin
                        w_state_nxt = IDLE;
                        w_done_nxt  = 1'b1;
                    end else begin
                        w_state_nxt = DRAIN;
                    end
                end else if (w_last_fire) begin
                    w_state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                if (!pulse_out || w_pulse_ending) begin
                    w_state_nxt = IDLE;
                    w_done_nxt  = 1'b1;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_done    <= 1'b0;
            r_cfg_err <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_done    <= w_done_nxt;
            r_cfg_err <= w_reject;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cfg       <= '0;
            r_per_cnt   <= '0;
            r_pulse_idx <= '0;
        end else begin
            if ((r_state == IDLE) && start) begin
                r_cfg.width  <= C_CNT_W'(cfg_width);
                r_cfg.period <= C_CNT_W'(cfg_period);
                r_cfg.count  <= C_IDX_W'(cfg_count);
            end
            if (w_accept) begin
                r_per_cnt   <= '0;
                r_pulse_idx <= '0;
            end else if (r_state != IDLE) begin
                // Keeps counting in DRAIN so the in-flight pulse end stays visible.
                r_per_cnt <= (w_per_cnt_inc == w_period) ? '0 : w_per_cnt_inc;
                if (w_fire) begin
                    r_pulse_idx <= r_pulse_idx + IDX_W'(1);
                end
            end
        end
    end

    assign w_gen_rst = ~rst_n;

    pulse_generate #(
        .CNT_W(CNT_W)
    ) u_pulse_generate (
        .clk         (clk),
        .rst         (w_gen_rst),
        .start_evt   (w_fire),
        .pulse_width (w_width),
        .pulse_out   (pulse_out)
    );

    assign busy      = (r_state != IDLE);
    assign done      = r_done;
    assign cfg_err   = r_cfg_err;
    assign pulse_idx = r_pulse_idx;

endmodule
`default_nettype wire

// File: tb/tb_pulse_train_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_pulse_train_ctrl : scoreboard bench for pulse_train_ctrl                 |
// | Revision            : 1.0                                                  |
// +----------------------------------------------------------------------------+
module tb_pulse_train_ctrl;

`ifdef PULSE_TRAIN_INFINITE_EN
    localparam int TB_IDX_W = 4;
    localparam bit INF_EN   = 1'b1;
`else
    localparam int TB_IDX_W = 16;
    localparam bit INF_EN   = 1'b0;
`endif

    logic                clk = 1'b0;
    logic                rst_n = 1'b0;
    logic                start = 1'b0;
    logic                stop = 1'b0;
    logic [31:0]         cfg_width = '0;
    logic [31:0]         cfg_period = '0;
    logic [TB_IDX_W-1:0] cfg_count = '0;
    logic                pulse_out;
    logic                busy;
    logic                done;
    logic                cfg_err;
    logic [TB_IDX_W-1:0] pulse_idx;

    pulse_train_ctrl #(
        .CNT_W(32),
        .IDX_W(TB_IDX_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .stop      (stop),
        .cfg_width (cfg_width),
        .cfg_period(cfg_period),
        .cfg_count (cfg_count),
        .pulse_out (pulse_out),
        .busy      (busy),
        .done      (done),
        .cfg_err   (cfg_err),
        .pulse_idx (pulse_idx)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct { int rise; int width; } pulse_exp_t;
    typedef struct { int at; int idx; } done_exp_t;

    pulse_exp_t q_pulse[$];
    done_exp_t  q_done[$];
    int         q_err[$];

    int n_tests = 0;
    int n_fail  = 0;
    int busy_from = 0;
    int busy_until = 0;
    int idx_hold = 0;
    bit mon_en = 1'b0;
    bit prev_pulse = 1'b0;
    int rise_c = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic unexpected(input string name);
        n_tests++;
        n_fail++;
        $display("FAIL %s: DUT event with no expected entry (cycle %0d)", name, cyc);
    endtask

    // Monitor: compares every observed output event against the scoreboard queues.
    always @(negedge clk) begin
        if (mon_en) begin
            pulse_exp_t p;
            done_exp_t  d;
            int         e;
            check("busy", busy, (cyc >= busy_from) && (cyc < busy_until));
            if (cyc >= busy_until) check("idx_hold", pulse_idx, idx_hold);
            if (pulse_out && !prev_pulse) rise_c = cyc;
            if (!pulse_out && prev_pulse) begin
                if (q_pulse.size() == 0) unexpected("pulse");
                else begin
                    p = q_pulse.pop_front();
                    check("pulse_rise", rise_c, p.rise);
                    check("pulse_width", cyc - rise_c, p.width);
                end
            end
            if (done) begin
                if (q_done.size() == 0) unexpected("done");
                else begin
                    d = q_done.pop_front();
                    check("done_cycle", cyc, d.at);
                    check("done_idx", pulse_idx, d.idx);
                end
            end
            if (cfg_err) begin
                if (q_err.size() == 0) unexpected("cfg_err");
                else begin
                    e = q_err.pop_front();
                    check("cfg_err_cycle", cyc, e);
                end
            end
            prev_pulse = pulse_out;
        end
    end

    // restart: -1 none, 0 random cycle inside the train, >0 fixed offset from start.
    task automatic run_train(input int w, input int p, input int n,
                             input int stop_at, input int restart);
        int t0, s, f_last, nf, r_last, done_c, restart_at, last_c;
        bit ok, inf;
        pulse_exp_t pe;
        done_exp_t  de;
        @(negedge clk);
        cfg_width  = 32'(w);
        cfg_period = 32'(p);
        cfg_count  = TB_IDX_W'(n);
        start = 1'b1;
        stop  = 1'b0;
        t0 = cyc;
        inf = (n == 0) && INF_EN;
        ok  = (w != 0) && (p > w) && ((n != 0) || INF_EN);
        restart_at = -1;
        if (!ok) begin
            q_err.push_back(t0 + 1);
            busy_from  = t0 + 1;
            busy_until = t0 + 1;
            last_c = t0 + 3;
        end else begin
            f_last = inf ? 32'h3fff_ffff : t0 + 1 + (n - 1) * p;
            s = (stop_at > 0) ? t0 + stop_at : -1;
            if (s > f_last) s = -1;
            nf = 0;
            for (int k = 0; ; k++) begin
                if (!inf && k >= n) break;
                if ((s >= 0) && (t0 + 1 + k * p >= s)) break;
                pe.rise  = t0 + 2 + k * p;
                pe.width = w;
                q_pulse.push_back(pe);
                nf++;
            end
            if (nf == 0) done_c = s + 1;
            else begin
                r_last = t0 + 2 + (nf - 1) * p;
                done_c = r_last + w;
                if ((s >= 0) && (s + 1 > done_c)) done_c = s + 1;
            end
            de.at  = done_c;
            de.idx = nf % (1 << TB_IDX_W);
            q_done.push_back(de);
            busy_from  = t0 + 1;
            busy_until = done_c;
            idx_hold   = de.idx;
            last_c     = done_c + 1;
            if (restart > 0) restart_at = restart;
            else if (restart == 0) restart_at = $urandom_range(1, done_c - t0 - 1);
        end
        for (int c = t0 + 1; c <= last_c; c++) begin
            @(negedge clk);
            start = (c < last_c) && (restart_at > 0) && (cyc == t0 + restart_at);
            if (start) begin
                cfg_width  = 32'($urandom_range(0, 6));
                cfg_period = 32'($urandom_range(0, 8));
                cfg_count  = TB_IDX_W'($urandom_range(0, 4));
            end
            stop = (c < last_c) && (stop_at > 0) && (cyc == t0 + stop_at);
        end
        start = 1'b0;
        stop  = 1'b0;
    endtask

    task automatic reset_mid_train();
        int t0;
        @(negedge clk);
        mon_en = 1'b0;
        cfg_width = 32'd3; cfg_period = 32'd5; cfg_count = TB_IDX_W'(4);
        start = 1'b1;
        t0 = cyc;
        @(negedge clk);
        start = 1'b0;
        while (cyc < t0 + 8) @(negedge clk);
        check("pre_reset_pulse", pulse_out, 1'b1);
        check("pre_reset_idx", pulse_idx, 2);
        #2 rst_n = 1'b0;
        #1;
        check("reset_pulse_out", pulse_out, 1'b0);
        check("reset_busy", busy, 1'b0);
        check("reset_idx", pulse_idx, 0);
        q_pulse.delete();
        q_done.delete();
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            check("post_reset_done", done, 1'b0);
            check("post_reset_pulse", pulse_out, 1'b0);
        end
        busy_from = 0; busy_until = 0; idx_hold = 0; prev_pulse = 1'b0;
        mon_en = 1'b1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $display("[TB] %0d tests run, %0d failed", n_tests + 1, n_fail + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        int w, p, n, sel, stop_at;
        repeat (3) @(negedge clk);
        check("rst_pulse_out", pulse_out, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_cfg_err", cfg_err, 1'b0);
        check("rst_idx", pulse_idx, 0);
        rst_n = 1'b1;
        mon_en = 1'b1;
        repeat (2) @(negedge clk);

        run_train(3, 5, 4, -1, -1);
        run_train(2, 10, 5, 13, -1);
        run_train(0, 4, 1, -1, -1);
        run_train(4, 4, 1, -1, -1);
        run_train(4, 2, 1, -1, -1);
        if (!INF_EN) run_train(3, 5, 0, -1, -1);
        run_train(2, 5, 4, 6, 6);
        run_train(1, 2, 3, -1, 0);
        reset_mid_train();

        for (int it = 0; it < 30; it++) begin
            w = $urandom_range(1, 6);
            p = w + $urandom_range(1, 6);
            n = $urandom_range(1, 5);
            sel = $urandom_range(0, 9);
            if (sel == 0) w = 0;
            if (sel == 1) p = $urandom_range(0, w);
            stop_at = ($urandom_range(0, 1) == 1) ? $urandom_range(1, n * p + 4) : -1;
            run_train(w, p, n, stop_at, ($urandom_range(0, 1) == 1) ? 0 : -1);
        end

`ifdef PULSE_TRAIN_INFINITE_EN
        run_train(1, 2, 0, 200, -1);
        run_train(2, 3, 0, 50, 0);
`endif

        repeat (3) @(negedge clk);
        mon_en = 1'b0;
        check("leftover_pulses", q_pulse.size(), 0);
        check("leftover_done", q_done.size(), 0);
        check("leftover_cfg_err", q_err.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pulse_train_ctrl.md
# pulse_train_ctrl

Sequencer that drives one `pulse_generate` stage to produce a train of `cfg_count` equal-width pulses at a fixed period, started and stopped by single-cycle commands. It sits between the register/control layer and the pulse output pin logic. It adds the period timing, pulse counting, early stop and completion status that a single-shot pulse generator does not provide.

## Interface
- `CNT_W`, 32: width of the width and period fields and counters.
- `IDX_W`, 16: width of the pulse-count field and index.

- `clk`  in  1  clock.
- `rst_n`  in  1  asynchronous active-low reset.
- `start`  in  1  single-cycle start command; latches configuration.
- `stop`  in  1  single-cycle stop command; ends the train early.
- `cfg_width`  in  CNT_W  pulse high time, in clk cycles.
- `cfg_period`  in  CNT_W  rising-edge-to-rising-edge spacing, in clk cycles.
- `cfg_count`  in  IDX_W  number of pulses in the train.
- `pulse_out`  out  1  generated pulse train.
- `busy`  out  1  train in progress.
- `done`  out  1  single-cycle completion strobe.
- `cfg_err`  out  1  single-cycle strobe: start rejected.
- `pulse_idx`  out  IDX_W  pulses fired since the last accepted start.

## Operation
- FSM states: IDLE, RUN, DRAIN.
- **IDLE, start = 1**: `cfg_width`, `cfg_period` and `cfg_count` are latched into shadow registers.
  - Rejected if `width == 0`, `period <= width`, or `count == 0` (`count == 0` only when the macro is off).
  - Rejected start: `cfg_err` = 1 for one cycle; FSM stays in IDLE.
  - Accepted start: `pulse_idx` cleared to 0, then go to RUN.
- **RUN**: period counter `per_cnt` runs 0..period-1 and wraps.
  - When `per_cnt == 0`, the internal `fire` is asserted (this is the `start_evt` of `pulse_generate`) and `pulse_idx` increments.
  - After the fire that brings `pulse_idx` to `count`, go to DRAIN.
- **DRAIN**: wait until `pulse_out` is low. Then assert `done` for one cycle, go to IDLE and drop `busy`.
- **stop in RUN**: no further fires; go to DRAIN. The pulse in flight completes its full width and is never truncated.
- **stop in IDLE or DRAIN**: no effect.
- **start while busy**: ignored, with no `cfg_err`.
- **stop and fire in the same cycle**: stop wins and the fire is suppressed.
- **start and stop together in IDLE**: start is evaluated and stop is ignored.
- `busy` = (state != IDLE).
- `pulse_idx` holds its final value in IDLE until the next accepted start.
- Arithmetic: comparisons are unsigned on CNT_W bits. `period <= width` is checked without subtraction, so there is no wrap-around.

## Timing
- Reset values: `pulse_out`, `busy`, `done` and `cfg_err` are 0; `pulse_idx` is 0; FSM is in IDLE; counters are 0.
- Reset mid-train aborts immediately: `pulse_out` drops asynchronously and `done` is not issued.
- Take `start` sampled at edge 0:
  - cycle 1: RUN, `fire` high.
  - cycles 2..W+1: `pulse_out` high.
  - pulse k (k = 0..N-1) rises at cycle 2 + kP.
- Latency is therefore 2 cycles from the start sample to the first rising edge of `pulse_out`.
- `done` is asserted in cycle 2 + (N-1)P + W, the first low cycle after the last pulse. `busy` falls in the same cycle.
- `cfg_err` is asserted in cycle 1.
- Stop sampled at cycle s during RUN: no fire at or after s. `done` follows on the first cycle in which `pulse_out` is low in DRAIN.
- `pulse_out` is registered with no combinational path from the inputs.

## Configuration
- Macro: `PULSE_TRAIN_INFINITE_EN`.
- Defined: `cfg_count == 0` selects an endless train. `pulse_idx` wraps modulo 2^IDX_W, and the train ends only on `stop`.
- Undefined: `cfg_count == 0` is a configuration error (`cfg_err`), and the infinite-mode logic is not compiled.

## Structure
- Package `pulse_pkg`:
  - FSM state enum `pt_state_e` (IDLE/RUN/DRAIN).
  - Default `CNT_W` and `IDX_W` constants.
  - A `pt_cfg_t` struct {width, period, count} for the shadow registers.
- One sub-module: the existing `pulse_generate`.
  - Its active-high reset is driven from `~rst_n`.
  - Its `start_evt` is driven by `fire`, and its `pulse_width` by the shadow width.
- The FSM, period counter and index live in this module.

## Test plan
- W=3, P=5, N=4, start at cycle 0 -> `pulse_out` high in cycles 2-4, 7-9, 12-14 and 17-19; `done` at cycle 20; `pulse_idx` = 4.
- W=2, P=10, N=5, stop at cycle 13 -> pulses at 2-3 and 12-13 only; `done` at 14; `pulse_idx` = 2.
- Rejected configurations -> each gives one `cfg_err` pulse, `busy` stays 0 and there is no `pulse_out`:
  - W=0, P=4, N=1.
  - W=4, P=4, N=1.
  - N=0 with the macro off.
- start while busy, with start and stop in the same cycle as a fire -> the second start is ignored and the suppressed fire yields no pulse.
- `rst_n` low at cycle 8 of a W=3, P=5 train -> `pulse_out`, `busy` and `pulse_idx` are 0 immediately, with no `done`.
- With the macro on, N=0, W=1, P=2 -> pulses continue for 200 cycles until `stop`; `pulse_idx` wraps correctly when IDX_W is set to 4.
